// File: rtl/instruction_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : instruction_fetch_unit
// Brief  : PC register, combinational ROM fetch and IF/ID register with early jump.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------

`ifndef NOP
`define NOP 6'b000000
`endif
`ifndef JMP
`define JMP 6'b010001
`endif

module instruction_fetch_unit #(
  parameter logic [9:0] RESET_PC   = 10'd0,
  parameter logic [5:0] JMP_OPCODE = `JMP,
  parameter logic [5:0] NOP_OPCODE = `NOP
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [9:0]  iBranchTarget,
  output logic [9:0]  oAddress,
  input  logic [15:0] iInstruction,
  output logic [15:0] oInstruction,
  output logic [9:0]  oPC,
  output logic        oValid
);

  localparam logic [0:0]  c_IDLE     = 1'b0;
  localparam logic [0:0]  c_RUN      = 1'b1;
  localparam logic [15:0] c_NOP_WORD = {NOP_OPCODE, 10'd0};

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [9:0]  r_pc;
  logic [9:0]  w_pc_next;
  logic [15:0] r_instr;
  logic [15:0] w_instr_next;
  logic [9:0]  r_opc;
  logic [9:0]  w_opc_next;
  logic        r_valid;
  logic        w_valid_next;
  logic        w_is_jmp;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= c_NOP_WORD;
      r_opc   <= 10'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_opc   <= w_opc_next;
      r_valid <= w_valid_next;
    end
  end

  // A redirect never changes the run state; only iEnable does.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (iEnable)  w_state_next = c_RUN;
      c_RUN:   if (!iEnable) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  assign w_is_jmp = (iInstruction[15:10] == JMP_OPCODE);

  always_comb begin
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_opc_next   = r_opc;
    w_valid_next = r_valid;
    if (iBranchTaken) begin
      w_pc_next    = iBranchTarget;
      w_instr_next = c_NOP_WORD;
      w_opc_next   = r_pc;
      w_valid_next = 1'b0;
    end else if (r_state == c_IDLE) begin
      w_instr_next = c_NOP_WORD;
      w_valid_next = 1'b0;
    end else if (!iStall) begin
      w_instr_next = iInstruction;
      w_opc_next   = r_pc;
      w_valid_next = 1'b1;
      w_pc_next    = w_is_jmp ? iInstruction[9:0] : r_pc + 10'd1;
    end
  end

  assign oAddress     = r_pc;
  assign oInstruction = r_instr;
  assign oPC          = r_opc;
  assign oValid       = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_instruction_fetch_unit
// Brief  : Directed and randomized bench for instruction_fetch_unit with a ROM model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [5:0]  c_JMP  = 6'h11;
  localparam logic [5:0]  c_NOP  = 6'h00;
  localparam logic [5:0]  c_ADDA = 6'h02;
  localparam logic [5:0]  c_LDA  = 6'h03;
  localparam logic [15:0] c_NOPW = {c_NOP, 10'd0};

  logic        Clock;
  logic        Reset;
  logic        iEnable;
  logic        iStall;
  logic        iBranchTaken;
  logic [9:0]  iBranchTarget;
  logic [9:0]  oAddress;
  logic [15:0] iInstruction;
  logic [15:0] oInstruction;
  logic [9:0]  oPC;
  logic        oValid;

  logic [15:0] rom [0:1023];
  assign iInstruction = rom[oAddress];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: architectural view of PC, IF/ID contents and run flag.
  logic [9:0]  m_pc;
  logic [15:0] m_ins;
  logic [9:0]  m_opc;
  logic        m_valid;
  bit          m_run;

  logic [36:0] act;
  assign act = {oAddress, oInstruction, oPC, oValid};

  instruction_fetch_unit #(
    .RESET_PC  (10'd0),
    .JMP_OPCODE(c_JMP),
    .NOP_OPCODE(c_NOP)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iEnable      (iEnable),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .oInstruction (oInstruction),
    .oPC          (oPC),
    .oValid       (oValid)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [36:0] exp_vec();
    return {m_pc, m_ins, m_opc, m_valid};
  endfunction

  task automatic model_reset();
    m_pc = 10'd0; m_ins = c_NOPW; m_opc = 10'd0; m_valid = 1'b0; m_run = 1'b0;
  endtask

  // Apply the fetch rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [15:0] word;
    word = rom[m_pc];
    if (iBranchTaken) begin
      m_opc = m_pc; m_pc = iBranchTarget; m_ins = c_NOPW; m_valid = 1'b0;
    end else if (!m_run) begin
      m_ins = c_NOPW; m_valid = 1'b0;
    end else if (!iStall) begin
      m_ins = word; m_opc = m_pc; m_valid = 1'b1;
      if (word[15:10] == c_JMP) m_pc = word[9:0];
      else                      m_pc = 10'((int'(m_pc) + 1) % 1024);
    end
    m_run = iEnable;
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; iEnable = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 10'd0;
    model_reset();
    #2;
    n_checks++;
    if (oAddress !== 10'd0) begin n_fails++; $display("FAIL reset_addr got %h want %h", oAddress, 10'd0); end
    n_checks++;
    if (oInstruction !== c_NOPW) begin n_fails++; $display("FAIL reset_instr got %h want %h", oInstruction, c_NOPW); end
    n_checks++;
    if (oPC !== 10'd0) begin n_fails++; $display("FAIL reset_opc got %h want %h", oPC, 10'd0); end
    n_checks++;
    if (oValid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", oValid); end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    n_checks++;
    if (act !== exp_vec()) begin n_fails++; $display("FAIL reset_idle got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_fetch_sequence();
    rom[0] = {c_ADDA, 10'($urandom)};
    rom[1] = {c_LDA, 10'($urandom)};
    rom[2] = {c_ADDA, 10'd5};
    iEnable = 1'b1;
    tick();
    n_checks++;
    if (oAddress !== 10'd0 || oValid !== 1'b0) begin
      n_fails++; $display("FAIL seq_enter got addr %h valid %b want 000 0", oAddress, oValid);
    end
    tick();
    n_checks++;
    if (oAddress !== 10'd1 || oInstruction !== rom[0] || oPC !== 10'd0 || oValid !== 1'b1) begin
      n_fails++; $display("FAIL seq_adda got %h want %h", act, {10'd1, rom[0], 10'd0, 1'b1});
    end
    tick();
    n_checks++;
    if (oAddress !== 10'd2 || oInstruction !== rom[1] || oPC !== 10'd1 || oValid !== 1'b1) begin
      n_fails++; $display("FAIL seq_lda got %h want %h", act, {10'd2, rom[1], 10'd1, 1'b1});
    end
  endtask

  task automatic test_early_jump();
    rom[18]   = {c_JMP, 10'd1000};
    rom[1000] = {c_JMP, 10'd1000};
    iBranchTaken = 1'b1; iBranchTarget = 10'd18;
    tick();
    iBranchTaken = 1'b0;
    n_checks++;
    if (oAddress !== 10'd18 || oValid !== 1'b0) begin
      n_fails++; $display("FAIL jmp_redirect got addr %h valid %b want 018 0", oAddress, oValid);
    end
    tick();
    n_checks++;
    if (act !== {10'd1000, c_JMP, 10'd1000, 10'd18, 1'b1}) begin
      n_fails++; $display("FAIL jmp_taken got %h want %h", act, {10'd1000, c_JMP, 10'd1000, 10'd18, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (act !== {10'd1000, c_JMP, 10'd1000, 10'd1000, 1'b1}) begin
        n_fails++; $display("FAIL jmp_self_loop got %h want %h", act, {10'd1000, c_JMP, 10'd1000, 10'd1000, 1'b1});
      end
    end
  endtask

  task automatic test_stall();
    rom[8]  = {c_LDA, 10'd77};
    rom[9]  = {c_ADDA, 10'd99};
    rom[10] = {c_ADDA, 10'd1};
    iBranchTaken = 1'b1; iBranchTarget = 10'd8;
    tick();
    iBranchTaken = 1'b0;
    tick();
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (act !== {10'd9, rom[8], 10'd8, 1'b1}) begin
        n_fails++; $display("FAIL stall_hold got %h want %h", act, {10'd9, rom[8], 10'd8, 1'b1});
      end
    end
    iStall = 1'b0;
    tick();
    n_checks++;
    if (act !== {10'd10, rom[9], 10'd9, 1'b1}) begin
      n_fails++; $display("FAIL stall_release got %h want %h", act, {10'd10, rom[9], 10'd9, 1'b1});
    end
  endtask

  task automatic test_branch_priority();
    rom[10] = {c_JMP, 10'd500};
    iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 10'd14;
    tick();
    iStall = 1'b0; iBranchTaken = 1'b0;
    n_checks++;
    if (oAddress !== 10'd14 || oValid !== 1'b0 || oInstruction !== c_NOPW) begin
      n_fails++; $display("FAIL branch_priority got %h want addr 00e nop valid 0", act);
    end
  endtask

  task automatic test_wrap();
    rom[1023] = c_NOPW;
    rom[0]    = c_NOPW;
    iBranchTaken = 1'b1; iBranchTarget = 10'd1023;
    tick();
    iBranchTaken = 1'b0;
    tick();
    n_checks++;
    if (oAddress !== 10'd0 || oPC !== 10'd1023 || oValid !== 1'b1) begin
      n_fails++; $display("FAIL pc_wrap got addr %h opc %h want 000 3ff", oAddress, oPC);
    end
  endtask

  task automatic test_idle_redirect();
    iEnable = 1'b0;
    tick();
    tick();
    iBranchTaken = 1'b1; iBranchTarget = 10'd100;
    tick();
    iBranchTaken = 1'b0;
    n_checks++;
    if (oAddress !== 10'd100 || oValid !== 1'b0) begin
      n_fails++; $display("FAIL idle_redirect got addr %h valid %b want 064 0", oAddress, oValid);
    end
    tick();
    n_checks++;
    if (oAddress !== 10'd100 || oValid !== 1'b0 || act !== exp_vec()) begin
      n_fails++; $display("FAIL idle_stays got %h want %h", act, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    rom[0]  = {c_ADDA, 10'd3};
    rom[30] = {c_LDA, 10'd30};
    rom[31] = {c_LDA, 10'd31};
    iEnable = 1'b1;
    iBranchTaken = 1'b1; iBranchTarget = 10'd30;
    tick();
    iBranchTaken = 1'b0;
    tick();
    #3;
    Reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (act !== {10'd0, c_NOPW, 10'd0, 1'b0}) begin
      n_fails++; $display("FAIL async_reset got %h want %h", act, {10'd0, c_NOPW, 10'd0, 1'b0});
    end
    @(posedge Clock);
    #1;
    n_checks++;
    if (act !== {10'd0, c_NOPW, 10'd0, 1'b0}) begin
      n_fails++; $display("FAIL reset_held got %h want %h", act, {10'd0, c_NOPW, 10'd0, 1'b0});
    end
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (act !== {10'd1, rom[0], 10'd0, 1'b1}) begin
      n_fails++; $display("FAIL reset_restart got %h want %h", act, {10'd1, rom[0], 10'd0, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 1024; a++) begin
      if ($urandom_range(0, 7) == 0) rom[a] = {c_JMP, 10'($urandom)};
      else                           rom[a] = 16'($urandom);
    end
    for (int i = 0; i < 3000; i++) begin
      iEnable       = ($urandom_range(0, 9) != 0);
      iStall        = ($urandom_range(0, 4) == 0);
      iBranchTaken  = ($urandom_range(0, 9) == 0);
      iBranchTarget = 10'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (act !== exp_vec()) begin n_fails++; $display("FAIL rand_reset got %h want %h", act, exp_vec()); end
        Reset = 1'b1;
      end
      tick();
      n_checks++;
      if (act !== exp_vec()) begin
        n_fails++; $display("FAIL rand_cycle %0d got %h want %h", i, act, exp_vec());
      end
    end
    iStall = 1'b0; iBranchTaken = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = c_NOPW;
    test_reset();
    test_fetch_sequence();
    test_early_jump();
    test_stall();
    test_branch_priority();
    test_wrap();
    test_idle_redirect();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
